// File: rtl/mycpu_defs.sv
// rtl/mycpu_defs.sv - shared encodings for the execute stage
package mycpu_defs;

    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_AND  = 4'd2;
    localparam logic [3:0] ALU_OP_OR   = 4'd3;
    localparam logic [3:0] ALU_OP_XOR  = 4'd4;
    localparam logic [3:0] ALU_OP_NOR  = 4'd5;
    localparam logic [3:0] ALU_OP_SLT  = 4'd6;
    localparam logic [3:0] ALU_OP_SLTU = 4'd7;
    localparam logic [3:0] ALU_OP_SLL  = 4'd8;
    localparam logic [3:0] ALU_OP_SRL  = 4'd9;
    localparam logic [3:0] ALU_OP_SRA  = 4'd10;
    localparam logic [3:0] ALU_OP_LUI  = 4'd11;

    localparam logic [2:0] MD_OP_NONE  = 3'd0;
    localparam logic [2:0] MD_OP_MULT  = 3'd1;
    localparam logic [2:0] MD_OP_MULTU = 3'd2;
    localparam logic [2:0] MD_OP_DIV   = 3'd3;
    localparam logic [2:0] MD_OP_DIVU  = 3'd4;
    localparam logic [2:0] MD_OP_MFHI  = 3'd5;
    localparam logic [2:0] MD_OP_MFLO  = 3'd6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_DIVU);
    endfunction

endpackage

// File: rtl/mycpu_div.sv
// rtl/mycpu_div.sv - iterative restoring divider on operand magnitudes
module mycpu_div
    import mycpu_defs::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        ack,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int CW = $clog2(DIV_ITER) + 1;

    div_state_t     state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [31:0]    rem, quo, dvs, dividend;
    logic           q_neg, r_neg, by_zero;
    logic [31:0]    a_mag, b_mag;
    logic [32:0]    trial;

    assign a_mag = (signed_op && a[31]) ? (~a + 32'd1) : a;
    assign b_mag = (signed_op && b[31]) ? (~b + 32'd1) : b;

    // Borrow out of the trial subtraction means the partial remainder stays.
    assign trial = {rem, quo[31]} - {1'b0, dvs};

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (start) state_nxt = DIV_BUSY;
            DIV_BUSY: if (cnt == CW'(DIV_ITER - 1)) state_nxt = DIV_DONE;
            DIV_DONE: if (ack) state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            dividend <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            by_zero  <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= a_mag;
            dvs      <= b_mag;
            dividend <= a;
            q_neg    <= signed_op && (a[31] ^ b[31]);
            r_neg    <= signed_op && a[31];
            by_zero  <= (b == 32'd0);
        end else if (state == DIV_BUSY) begin
            rem <= trial[32] ? {rem[30:0], quo[31]} : trial[31:0];
            quo <= {quo[30:0], ~trial[32]};
            cnt <= cnt + CW'(1);
        end
    end

    assign busy      = (state == DIV_BUSY);
    assign done      = (state == DIV_DONE);
    assign quotient  = by_zero ? 32'hFFFF_FFFF : (q_neg ? (~quo + 32'd1) : quo);
    assign remainder = by_zero ? dividend : (r_neg ? (~rem + 32'd1) : rem);

endmodule

// File: rtl/mycpu_exe_stage.sv
// rtl/mycpu_exe_stage.sv - MIPS execute stage with ALU, HI/LO and data SRAM request
module mycpu_exe_stage
    import mycpu_defs::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ds_valid,
    output logic        es_allowin,
    input  logic [31:0] ds_pc,
    input  logic [3:0]  ds_alu_op,
    input  logic [2:0]  ds_md_op,
    input  logic [31:0] ds_src1,
    input  logic [31:0] ds_src2,
    input  logic [31:0] ds_st_data,
    input  logic [4:0]  ds_dest,
    input  logic        ds_rf_we,
    input  logic        ds_mem_re,
    input  logic        ds_mem_we,
    input  logic        ms_allowin,
    output logic        es_to_ms_valid,
    output logic [31:0] es_pc,
    output logic [31:0] es_result,
    output logic [4:0]  es_dest,
    output logic        es_rf_we,
    output logic        es_mem_re,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_wen,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata
);

    logic        es_valid;
    logic [3:0]  es_alu_op;
    logic [2:0]  es_md_op;
    logic [31:0] es_src1, es_src2, es_st_data;
    logic        es_mem_we;
    logic [31:0] hi, lo;

    logic        is_div, es_ready_go, es_leave;
    logic        div_busy, div_done, mul_signed;
    logic [31:0] div_q, div_r, alu_result, mem_addr;
    logic [63:0] mul_a, mul_b, product;
    logic [4:0]  sa;

    assign is_div         = is_div_op(es_md_op);
    assign es_ready_go    = !(is_div && !div_done);
    assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go;
    assign es_leave       = es_to_ms_valid && ms_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid <= 1'b0;
        end else if (es_allowin) begin
            es_valid <= ds_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_pc      <= '0;
            es_alu_op  <= '0;
            es_md_op   <= '0;
            es_src1    <= '0;
            es_src2    <= '0;
            es_st_data <= '0;
            es_dest    <= '0;
            es_rf_we   <= 1'b0;
            es_mem_re  <= 1'b0;
            es_mem_we  <= 1'b0;
        end else if (ds_valid && es_allowin) begin
            es_pc      <= ds_pc;
            es_alu_op  <= ds_alu_op;
            es_md_op   <= ds_md_op;
            es_src1    <= ds_src1;
            es_src2    <= ds_src2;
            es_st_data <= ds_st_data;
            es_dest    <= ds_dest;
            es_rf_we   <= ds_rf_we;
            es_mem_re  <= ds_mem_re;
            es_mem_we  <= ds_mem_we;
        end
    end

    assign sa       = es_src1[4:0];
    assign mem_addr = es_src1 + es_src2;

    always_comb begin
        alu_result = '0;
        case (es_alu_op)
            ALU_OP_ADD:  alu_result = es_src1 + es_src2;
            ALU_OP_SUB:  alu_result = es_src1 - es_src2;
            ALU_OP_AND:  alu_result = es_src1 & es_src2;
            ALU_OP_OR:   alu_result = es_src1 | es_src2;
            ALU_OP_XOR:  alu_result = es_src1 ^ es_src2;
            ALU_OP_NOR:  alu_result = ~(es_src1 | es_src2);
            ALU_OP_SLT:  alu_result = {31'd0, $signed(es_src1) < $signed(es_src2)};
            ALU_OP_SLTU: alu_result = {31'd0, es_src1 < es_src2};
            ALU_OP_SLL:  alu_result = es_src2 << sa;
            ALU_OP_SRL:  alu_result = es_src2 >> sa;
            ALU_OP_SRA:  alu_result = $signed(es_src2) >>> sa;
            ALU_OP_LUI:  alu_result = es_src2 << 16;
            default:     alu_result = '0;
        endcase
    end

    // Extending both operands to 64 bits lets one multiplier serve MULT and MULTU.
    assign mul_signed = (es_md_op == MD_OP_MULT);
    assign mul_a      = {{32{mul_signed & es_src1[31]}}, es_src1};
    assign mul_b      = {{32{mul_signed & es_src2[31]}}, es_src2};
    assign product    = mul_a * mul_b;

    mycpu_div #(.DIV_ITER(DIV_ITER)) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (es_valid && is_div && !div_busy && !div_done),
        .ack       (es_leave),
        .signed_op (es_md_op == MD_OP_DIV),
        .a         (es_src1),
        .b         (es_src2),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // HI/LO change only on the handoff edge, so a following MFHI/MFLO sees the new value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (es_leave) begin
            if (es_md_op == MD_OP_MULT || es_md_op == MD_OP_MULTU) begin
                hi <= product[63:32];
                lo <= product[31:0];
            end else if (is_div) begin
                hi <= div_r;
                lo <= div_q;
            end
        end
    end

    always_comb begin
        es_result = alu_result;
        if (es_md_op == MD_OP_MFHI) begin
            es_result = hi;
        end else if (es_md_op == MD_OP_MFLO) begin
            es_result = lo;
        end else if (es_mem_re || es_mem_we) begin
            es_result = mem_addr;
        end
    end

    assign data_sram_en    = es_leave && (es_mem_re || es_mem_we);
    assign data_sram_wen   = {4{es_mem_we}};
    assign data_sram_addr  = mem_addr;
    assign data_sram_wdata = es_st_data;

endmodule

// File: tb/tb_mycpu_exe_stage.sv
// tb/tb_mycpu_exe_stage.sv - directed bench with a behavioural execute-stage model
module tb_mycpu_exe_stage;
    import mycpu_defs::*;

    localparam int DIV_ITER = 32;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ds_valid;
    logic        es_allowin;
    logic [31:0] ds_pc;
    logic [3:0]  ds_alu_op;
    logic [2:0]  ds_md_op;
    logic [31:0] ds_src1, ds_src2, ds_st_data;
    logic [4:0]  ds_dest;
    logic        ds_rf_we, ds_mem_re, ds_mem_we;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [31:0] es_pc, es_result;
    logic [4:0]  es_dest;
    logic        es_rf_we, es_mem_re;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata;

    always #5 clk = ~clk;

    mycpu_exe_stage #(.DIV_ITER(DIV_ITER)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ds_valid        (ds_valid),
        .es_allowin      (es_allowin),
        .ds_pc           (ds_pc),
        .ds_alu_op       (ds_alu_op),
        .ds_md_op        (ds_md_op),
        .ds_src1         (ds_src1),
        .ds_src2         (ds_src2),
        .ds_st_data      (ds_st_data),
        .ds_dest         (ds_dest),
        .ds_rf_we        (ds_rf_we),
        .ds_mem_re       (ds_mem_re),
        .ds_mem_we       (ds_mem_we),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_pc           (es_pc),
        .es_result       (es_result),
        .es_dest         (es_dest),
        .es_rf_we        (es_rf_we),
        .es_mem_re       (es_mem_re),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: one instruction slot, its age in EXE, and architectural HI/LO.
    logic        m_valid;
    int          m_age;
    logic [3:0]  m_alu;
    logic [2:0]  m_md;
    logic [31:0] m_s1, m_s2, m_sd, m_pc, m_hi, m_lo;
    logic [4:0]  m_dest;
    logic        m_rfwe, m_re, m_we;

    function automatic logic model_ready();
        return !(m_valid && (m_md == MD_OP_DIV || m_md == MD_OP_DIVU) && m_age < DIV_ITER + 1);
    endfunction

    function automatic logic [31:0] model_result();
        if (m_md == MD_OP_MFHI) return m_hi;
        if (m_md == MD_OP_MFLO) return m_lo;
        if (m_re || m_we) return m_s1 + m_s2;
        case (m_alu)
            ALU_OP_ADD:  return m_s1 + m_s2;
            ALU_OP_SUB:  return m_s1 - m_s2;
            ALU_OP_AND:  return m_s1 & m_s2;
            ALU_OP_OR:   return m_s1 | m_s2;
            ALU_OP_XOR:  return m_s1 ^ m_s2;
            ALU_OP_NOR:  return ~(m_s1 | m_s2);
            ALU_OP_SLT:  return ($signed(m_s1) < $signed(m_s2)) ? 32'd1 : 32'd0;
            ALU_OP_SLTU: return (m_s1 < m_s2) ? 32'd1 : 32'd0;
            ALU_OP_SLL:  return m_s2 << m_s1[4:0];
            ALU_OP_SRL:  return m_s2 >> m_s1[4:0];
            ALU_OP_SRA:  return 32'($signed(m_s2) >>> m_s1[4:0]);
            ALU_OP_LUI:  return {m_s2[15:0], 16'h0000};
            default:     return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge resetn) begin
        logic        rdy, alw;
        logic [63:0] p;
        if (!resetn) begin
            m_valid = 1'b0;
            m_age   = 0;
            m_hi    = '0;
            m_lo    = '0;
            m_alu = '0; m_md = '0; m_s1 = '0; m_s2 = '0; m_sd = '0; m_pc = '0;
            m_dest = '0; m_rfwe = 1'b0; m_re = 1'b0; m_we = 1'b0;
        end else begin
            rdy = model_ready();
            alw = !m_valid || (rdy && ms_allowin);
            if (m_valid && rdy && ms_allowin) begin
                case (m_md)
                    MD_OP_MULT: begin
                        p = 64'(longint'($signed(m_s1)) * longint'($signed(m_s2)));
                        m_hi = p[63:32]; m_lo = p[31:0];
                    end
                    MD_OP_MULTU: begin
                        p = {32'd0, m_s1} * {32'd0, m_s2};
                        m_hi = p[63:32]; m_lo = p[31:0];
                    end
                    MD_OP_DIV, MD_OP_DIVU: begin
                        if (m_s2 == 32'd0) begin
                            m_lo = 32'hFFFF_FFFF; m_hi = m_s1;
                        end else if (m_md == MD_OP_DIV) begin
                            m_lo = 32'($signed(m_s1) / $signed(m_s2));
                            m_hi = 32'($signed(m_s1) % $signed(m_s2));
                        end else begin
                            m_lo = m_s1 / m_s2; m_hi = m_s1 % m_s2;
                        end
                    end
                    default: ;
                endcase
            end
            if (alw) begin
                m_valid = ds_valid;
                m_age   = 0;
                if (ds_valid) begin
                    m_alu = ds_alu_op; m_md = ds_md_op; m_s1 = ds_src1; m_s2 = ds_src2;
                    m_sd = ds_st_data; m_pc = ds_pc; m_dest = ds_dest;
                    m_rfwe = ds_rf_we; m_re = ds_mem_re; m_we = ds_mem_we;
                end
            end else if (m_valid) begin
                m_age++;
            end
        end
    end

    typedef struct {
        logic        has;
        logic [31:0] val;
    } lit_t;
    lit_t lit_q[$];

    int          en_cnt = 0;
    logic [3:0]  en_wen;
    logic [31:0] en_addr, en_wdata;

    always @(negedge clk) begin
        logic rdy;
        lit_t l;
        rdy = model_ready();
        check("es_to_ms_valid", 32'(es_to_ms_valid), 32'(m_valid && rdy));
        check("es_allowin", 32'(es_allowin), 32'(!m_valid || (rdy && ms_allowin)));
        check("data_sram_en", 32'(data_sram_en), 32'(m_valid && rdy && ms_allowin && (m_re || m_we)));
        if (m_valid && rdy) begin
            check("es_result", es_result, model_result());
            check("es_pc", es_pc, m_pc);
            check("es_dest", 32'(es_dest), 32'(m_dest));
            check("es_rf_we", 32'(es_rf_we), 32'(m_rfwe));
            check("es_mem_re", 32'(es_mem_re), 32'(m_re));
        end
        if (data_sram_en) begin
            check("sram_wen", 32'(data_sram_wen), m_we ? 32'hF : 32'h0);
            check("sram_addr", data_sram_addr, m_s1 + m_s2);
            check("sram_wdata", data_sram_wdata, m_sd);
            en_cnt++;
            en_wen = data_sram_wen; en_addr = data_sram_addr; en_wdata = data_sram_wdata;
        end
        if (resetn && es_to_ms_valid && ms_allowin) begin
            if (lit_q.size() == 0) begin
                check("retire_without_issue", 32'd1, 32'd0);
            end else begin
                l = lit_q.pop_front();
                if (l.has) check("literal_result", es_result, l.val);
            end
        end
    end

    logic [31:0] pc_ctr = 32'hBFC0_0000;

    task automatic issue(input logic [3:0] alu, input logic [2:0] md, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] sd, input logic rfwe,
                         input logic re, input logic we, input logic has, input logic [31:0] lit,
                         output int waited);
        logic acc;
        lit_t l;
        ds_alu_op = alu; ds_md_op = md; ds_src1 = s1; ds_src2 = s2; ds_st_data = sd;
        ds_rf_we = rfwe; ds_mem_re = re; ds_mem_we = we;
        ds_pc = pc_ctr; ds_dest = pc_ctr[6:2];
        pc_ctr = pc_ctr + 32'd4;
        ds_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            acc = es_allowin;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 200) begin
                check("issue_timeout", 32'(waited), 32'd0);
                break;
            end
        end
        if (acc) begin
            l.has = has; l.val = lit;
            lit_q.push_back(l);
        end
        ds_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        resetn = 1'b0; ds_valid = 1'b0; ms_allowin = 1'b1;
        ds_pc = '0; ds_alu_op = '0; ds_md_op = '0; ds_src1 = '0; ds_src2 = '0;
        ds_st_data = '0; ds_dest = '0; ds_rf_we = 1'b0; ds_mem_re = 1'b0; ds_mem_we = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_allowin", 32'(es_allowin), 32'd1);
        check("reset_valid", 32'(es_to_ms_valid), 32'd0);
        check("reset_sram_en", 32'(data_sram_en), 32'd0);
        check("reset_pc", es_pc, 32'd0);
        resetn = 1'b1;
        idle(1);

        issue(ALU_OP_ADD, MD_OP_NONE, 32'd5, 32'hFFFF_FFFD, 0, 1, 0, 0, 1, 32'd2, w);
        idle(1);
        check("add_single_cycle_gone", 32'(es_to_ms_valid), 32'd0);

        issue(ALU_OP_ADD, MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 0, 0, 0, w);
        issue(ALU_OP_ADD, MD_OP_MFLO, 0, 0, 0, 1, 0, 0, 1, 32'hFFFF_FFFD, w);
        check("div_stall_cycles", 32'(w), 32'(DIV_ITER + 1));
        issue(ALU_OP_ADD, MD_OP_MFHI, 0, 0, 0, 1, 0, 0, 1, 32'hFFFF_FFFF, w);

        issue(ALU_OP_ADD, MD_OP_DIVU, 32'd10, 32'd0, 0, 0, 0, 0, 0, 0, w);
        issue(ALU_OP_ADD, MD_OP_MFLO, 0, 0, 0, 1, 0, 0, 1, 32'hFFFF_FFFF, w);
        issue(ALU_OP_ADD, MD_OP_MFHI, 0, 0, 0, 1, 0, 0, 1, 32'd10, w);
        idle(2);

        en_cnt = 0;
        ms_allowin = 1'b0;
        issue(ALU_OP_ADD, MD_OP_NONE, 32'h1000, 32'd4, 32'hDEAD_BEEF, 0, 0, 1, 1, 32'h1004, w);
        idle(3);
        check("sw_no_req_in_stall", 32'(en_cnt), 32'd0);
        ms_allowin = 1'b1;
        idle(2);
        check("sw_req_count", 32'(en_cnt), 32'd1);
        check("sw_wen", 32'(en_wen), 32'hF);
        check("sw_addr", en_addr, 32'h1004);
        check("sw_wdata", en_wdata, 32'hDEAD_BEEF);

        issue(ALU_OP_ADD, MD_OP_MULT, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 0, 0, 0, w);
        issue(ALU_OP_ADD, MD_OP_MFHI, 0, 0, 0, 1, 0, 0, 1, 32'hFFFF_FFFF, w);
        issue(ALU_OP_ADD, MD_OP_MFLO, 0, 0, 0, 1, 0, 0, 1, 32'hFFFF_FFFE, w);
        issue(ALU_OP_ADD, MD_OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 0, 0, 0, w);
        issue(ALU_OP_ADD, MD_OP_MFHI, 0, 0, 0, 1, 0, 0, 1, 32'd1, w);

        issue(ALU_OP_SUB,  MD_OP_NONE, 32'd3, 32'd5, 0, 1, 0, 0, 1, 32'hFFFF_FFFE, w);
        issue(ALU_OP_SLT,  MD_OP_NONE, 32'hFFFF_FFFF, 32'd1, 0, 1, 0, 0, 1, 32'd1, w);
        issue(ALU_OP_SLTU, MD_OP_NONE, 32'hFFFF_FFFF, 32'd1, 0, 1, 0, 0, 1, 32'd0, w);
        issue(ALU_OP_SLL,  MD_OP_NONE, 32'd3, 32'd1, 0, 1, 0, 0, 1, 32'd8, w);
        issue(ALU_OP_SRL,  MD_OP_NONE, 32'd1, 32'h8000_0000, 0, 1, 0, 0, 1, 32'h4000_0000, w);
        issue(ALU_OP_SRA,  MD_OP_NONE, 32'd4, 32'h8000_0000, 0, 1, 0, 0, 1, 32'hF800_0000, w);
        issue(ALU_OP_LUI,  MD_OP_NONE, 32'd0, 32'h0000_1234, 0, 1, 0, 0, 1, 32'h1234_0000, w);
        issue(ALU_OP_NOR,  MD_OP_NONE, 32'd0, 32'd0, 0, 1, 0, 0, 1, 32'hFFFF_FFFF, w);
        issue(ALU_OP_XOR,  MD_OP_NONE, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 1, 0, 0, 1, 32'h0FF0_0FF0, w);
        issue(ALU_OP_AND,  MD_OP_NONE, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 1, 0, 0, 1, 32'hF000_F000, w);
        issue(ALU_OP_OR,   MD_OP_NONE, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 1, 0, 0, 1, 32'hFFF0_FFF0, w);
        issue(ALU_OP_ADD,  MD_OP_NONE, 32'h2000, 32'd8, 0, 1, 1, 0, 1, 32'h2008, w);
        issue(ALU_OP_ADD,  MD_OP_DIV, 32'd100, 32'hFFFF_FFF9, 0, 0, 0, 0, 0, 0, w);
        issue(ALU_OP_ADD,  MD_OP_MFLO, 0, 0, 0, 1, 0, 0, 1, 32'hFFFF_FFF2, w);
        issue(ALU_OP_ADD,  MD_OP_MFHI, 0, 0, 0, 1, 0, 0, 1, 32'd2, w);
        idle(2);

        issue(ALU_OP_ADD, MD_OP_DIV, 32'd1000, 32'd7, 0, 0, 0, 0, 0, 0, w);
        idle(10);
        resetn = 1'b0;
        lit_q.delete();
        #1;
        check("reset_mid_div_valid", 32'(es_to_ms_valid), 32'd0);
        idle(1);
        resetn = 1'b1;
        check("after_reset_allowin", 32'(es_allowin), 32'd1);
        issue(ALU_OP_ADD, MD_OP_MFHI, 0, 0, 0, 1, 0, 0, 1, 32'd0, w);
        check("after_reset_accept_wait", 32'(w), 32'd0);
        issue(ALU_OP_ADD, MD_OP_MFLO, 0, 0, 0, 1, 0, 0, 1, 32'd0, w);
        idle(3);
        check("all_retired", 32'(lit_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
